key_pulse_gen: RTL and testbench
================================

// Module: key_pulse_gen
// PURPOSE
//  Upstream stage of the T-flip-flop counter/decimal display. Turns a raw pushbutton into
//  clean single-cycle count enables. Synchronises and debounces key_n, emits one pulse per
//  press, and emits auto-repeat pulses while the key is held (when auto_en=1).
//  pulse drives the counter's T-chain enable, so the counter advances once per pulse.
// PARAMETERS
//  DEBOUNCE_CYC      1_000_000   consecutive stable cycles needed to accept a new level (>=1)
//  REPEAT_DELAY_CYC  25_000_000  cycles from press pulse to first repeat pulse (>=2)
//  REPEAT_RATE_CYC   5_000_000   cycles between successive repeat pulses (>=2)
// PORTS
//  Clk        in   1  clock
//  Rst        in   1  reset, synchronous, active-low
//  key_n      in   1  raw pushbutton, active-low, asynchronous to Clk
//  auto_en    in   1  1 = auto-repeat allowed while held (switch, treated as quasi-static)
//  pulse      out  1  one-cycle count enable
//  key_level  out  1  debounced key state, 1 = pressed
// BEHAVIOUR
//  Reset (Rst=0 at a rising Clk edge): pulse=0, key_level=0, state=IDLE, timers=0,
//   synchroniser flops=1 (released), debounce counter=0. Reset overrides all other inputs.
//  Synchroniser: 2 flops on key_n. Debounce: compare synchronised level with key_level.
//   Counter increments while they differ and clears when they match. On reaching
//   DEBOUNCE_CYC, key_level takes the new value and the counter clears.
//   A glitch shorter than DEBOUNCE_CYC cycles never changes key_level.
//  Latency: key_n low and stable from edge k -> key_level=1 and pulse=1 after edge
//   k+2+DEBOUNCE_CYC, pulse=0 after the next edge.
//  FSM (all outputs registered):
//   IDLE:   key_level rising -> pulse=1, timer=REPEAT_DELAY_CYC-1, go HOLD.
//   HOLD:   key_level=0 -> IDLE, no pulse.
//           timer!=0 -> decrement.
//           timer==0 and auto_en=1 -> pulse=1, timer=REPEAT_RATE_CYC-1, go REPEAT.
//           timer==0 and auto_en=0 -> stay HOLD, no pulse.
//   REPEAT: key_level=0 -> IDLE.
//           timer==0 -> pulse=1, reload REPEAT_RATE_CYC-1.
//           auto_en=0 -> back to HOLD with timer=0; no pulse.
//   Release and timer expiry in the same cycle: release wins, no pulse.
//  pulse is never high on two consecutive cycles. Exactly one press pulse per
//   debounced press.
//  Key held across reset deassertion: synchroniser starts released, so after
//   2+DEBOUNCE_CYC cycles the press is accepted and one pulse is emitted.
//  Widths: each timer/counter is $clog2(max value+1) bits. No wrap: counters saturate
//   at their terminal value and are reloaded by the FSM.
// STRUCTURE
//  Shared header key_pulse_defs.vh: state encodings ST_IDLE=2'd0, ST_HOLD=2'd1,
//   ST_REPEAT=2'd2, and default timing constants for the 50 MHz board clock.
//  One sub-module, debounce_filter (synchroniser + debounce counter -> key_level).
//  key_pulse_gen itself holds the FSM and repeat timer.
// TESTING (bench params DEBOUNCE_CYC=4, REPEAT_DELAY_CYC=10, REPEAT_RATE_CYC=3)
//  1 Rst=0 for 3 cycles with key_n toggling -> pulse=0, key_level=0 throughout.
//  2 key_n low for 20 cycles, auto_en=0 -> key_level rises 6 cycles after the edge;
//    exactly 1 pulse; none during the hold.
//  3 key_n bounce: low 3, high 1, low 2, high 5 cycles -> key_level stays 0, no pulse.
//  4 auto_en=1, key_n low 30 cycles -> press pulse at t, repeats at t+10, t+13, t+16 ...;
//    pulses stop once key_level falls.
//  5 auto_en=1, hold until first repeat, drop auto_en -> no more pulses; release -> IDLE;
//    re-press -> 1 pulse.
//  6 Rst=0 mid-REPEAT with key held -> outputs 0 next cycle; after release of Rst,
//    1 pulse after 6 cycles.

Source files
------------

// File: rtl/key_pulse_gen_pkg.sv
// Shared types and board-level timing defaults for the pushbutton pulse generator.
// State encodings keep the legacy values so existing probes/decoders still match.
package key_pulse_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } state_t;

  // 50 MHz board clock: 20 ms debounce, 500 ms repeat delay, 100 ms repeat period
  localparam int unsigned DEF_DEBOUNCE_CYC     = 1_000_000;
  localparam int unsigned DEF_REPEAT_DELAY_CYC = 25_000_000;
  localparam int unsigned DEF_REPEAT_RATE_CYC  = 5_000_000;

  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/key_pulse_gen_debounce_filter.sv
// Two-flop synchroniser plus stability counter producing the debounced key state.
// level_next exposes the value key_level takes at the coming edge.
module debounce_filter
  import key_pulse_gen_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
  input  logic Clk,
  input  logic Rst,
  input  logic key_n,
  output logic key_level,
  output logic level_next
);

  localparam int unsigned CW = cnt_width(DEBOUNCE_CYC);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;
  logic          differ;
  logic          accept;

  always_comb begin
    differ     = (~sync2) != key_level;
    accept     = differ && (cnt == CW'(DEBOUNCE_CYC - 1));
    level_next = accept ? ~key_level : key_level;
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      cnt       <= '0;
      key_level <= 1'b0;
    end else begin
      sync1     <= key_n;
      sync2     <= sync1;
      key_level <= level_next;
      if (!differ || accept)
        cnt <= '0;
      else if (cnt != CW'(DEBOUNCE_CYC))
        cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/key_pulse_gen.sv
// Pushbutton to single-cycle count-enable converter with optional auto-repeat.
// Drives the T-flip-flop counter's enable chain: one pulse per accepted press/repeat.
module key_pulse_gen
  import key_pulse_gen_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC     = DEF_DEBOUNCE_CYC,
  parameter int unsigned REPEAT_DELAY_CYC = DEF_REPEAT_DELAY_CYC,
  parameter int unsigned REPEAT_RATE_CYC  = DEF_REPEAT_RATE_CYC
) (
  input  logic Clk,
  input  logic Rst,
  input  logic key_n,
  input  logic auto_en,
  output logic pulse,
  output logic key_level
);

  localparam int unsigned TMAX = (REPEAT_DELAY_CYC > REPEAT_RATE_CYC) ?
                                 REPEAT_DELAY_CYC - 1 : REPEAT_RATE_CYC - 1;
  localparam int unsigned TW   = cnt_width(TMAX);

  state_t        state, state_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic          pulse_nxt;
  logic          level_next;

  debounce_filter #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_debounce (
    .Clk       (Clk),
    .Rst       (Rst),
    .key_n     (key_n),
    .key_level (key_level),
    .level_next(level_next)
  );

  // FSM reacts to the debouncer's next level so pulse and key_level rise on the
  // same edge, and a release always beats a same-cycle timer expiry.
  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    pulse_nxt = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (level_next && !key_level) begin
          pulse_nxt = 1'b1;
          timer_nxt = TW'(REPEAT_DELAY_CYC - 1);
          state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (!level_next) begin
          state_nxt = ST_IDLE;
          timer_nxt = '0;
        end else if (timer != '0) begin
          timer_nxt = timer - 1'b1;
        end else if (auto_en) begin
          pulse_nxt = 1'b1;
          timer_nxt = TW'(REPEAT_RATE_CYC - 1);
          state_nxt = ST_REPEAT;
        end
      end
      ST_REPEAT: begin
        if (!level_next) begin
          state_nxt = ST_IDLE;
          timer_nxt = '0;
        end else if (!auto_en) begin
          state_nxt = ST_HOLD;
          timer_nxt = '0;
        end else if (timer == '0) begin
          pulse_nxt = 1'b1;
          timer_nxt = TW'(REPEAT_RATE_CYC - 1);
        end else begin
          timer_nxt = timer - 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        timer_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state <= ST_IDLE;
      timer <= '0;
      pulse <= 1'b0;
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
      pulse <= pulse_nxt;
    end
  end

endmodule

// File: tb/tb_key_pulse_gen.sv
// Directed phases plus random key activity, checked every cycle against a
// sample-window / pulse-schedule reference model of the pushbutton behaviour.
module tb_key_pulse_gen;

  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RR = 3;

  logic Clk = 1'b0;
  logic Rst, key_n, auto_en;
  logic pulse, key_level;

  always #5 Clk = ~Clk;

  key_pulse_gen #(
    .DEBOUNCE_CYC    (D),
    .REPEAT_DELAY_CYC(RD),
    .REPEAT_RATE_CYC (RR)
  ) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .key_n    (key_n),
    .auto_en  (auto_en),
    .pulse    (pulse),
    .key_level(key_level)
  );

  int    errors = 0;
  int    checks = 0;
  int    n      = 0;
  string phase  = "init";

  // reference model state
  bit   smp[$]   = '{1'b1, 1'b1};
  bit   win[$];
  logic m_level  = 1'b0;
  logic m_pulse  = 1'b0;
  bit   m_rep    = 1'b0;
  int   m_next   = 0;

  task automatic model_edge(input logic r, input logic k, input logic a);
    bit   s2;
    bit   agree;
    logic old;
    n++;
    if (!r) begin
      smp = '{1'b1, 1'b1};
      win.delete();
      m_level = 1'b0;
      m_pulse = 1'b0;
      m_rep   = 1'b0;
      m_next  = 0;
      return;
    end
    s2 = smp[0];
    smp.push_back(k);
    void'(smp.pop_front());
    old = m_level;
    win.push_back(s2);
    if (win.size() > D) void'(win.pop_front());
    // active-low sample disagrees with the level when the two bits are equal
    if (win.size() == D) begin
      agree = 1'b1;
      foreach (win[i]) if (win[i] != m_level) agree = 1'b0;
      if (agree) begin
        m_level = ~m_level;
        win.delete();
      end
    end
    m_pulse = 1'b0;
    if (!m_level) begin
      m_rep = 1'b0;
    end else if (!old) begin
      m_pulse = 1'b1;
      m_rep   = 1'b0;
      m_next  = n + RD;
    end else if (m_rep && !a) begin
      m_rep  = 1'b0;
      m_next = n + 1;
    end else if (a && n >= m_next) begin
      m_pulse = 1'b1;
      m_rep   = 1'b1;
      m_next  = n + RR;
    end
  endtask

  task automatic step(input logic r, input logic k, input logic a);
    Rst = r; key_n = k; auto_en = a;
    @(posedge Clk);
    model_edge(r, k, a);
    #1;
    checks++;
    assert (pulse === m_pulse) else begin
      errors++;
      $error("FAIL %s pulse: got %b expected %b (cycle %0d)", phase, pulse, m_pulse, n);
    end
    checks++;
    assert (key_level === m_level) else begin
      errors++;
      $error("FAIL %s key_level: got %b expected %b (cycle %0d)", phase, key_level, m_level, n);
    end
  endtask

  task automatic run(input int cyc, input logic r, input logic k, input logic a,
                     output int pcnt, output int first_p, output int first_l);
    pcnt = 0; first_p = -1; first_l = -1;
    for (int i = 1; i <= cyc; i++) begin
      step(r, k, a);
      if (pulse === 1'b1) begin
        pcnt++;
        if (first_p < 0) first_p = i;
      end
      if (key_level === 1'b1 && first_l < 0) first_l = i;
    end
  endtask

  task automatic expect_int(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  initial begin
    int pc, fp, fl, tot, lv;
    logic k, a;
    int len;

    phase = "reset";
    for (int i = 0; i < 3; i++) step(1'b0, logic'(i % 2), 1'b0);
    run(4, 1'b1, 1'b1, 1'b0, pc, fp, fl);

    phase = "press";
    run(20, 1'b1, 1'b0, 1'b0, pc, fp, fl);
    expect_int("press_level_latency", fl, 6);
    expect_int("press_pulse_count", pc, 1);
    expect_int("press_pulse_latency", fp, 6);
    run(10, 1'b1, 1'b1, 1'b0, pc, fp, fl);
    expect_int("release_pulse_count", pc, 0);

    phase = "bounce";
    tot = 0; lv = 0;
    run(3, 1'b1, 1'b0, 1'b0, pc, fp, fl); tot += pc; lv += (fl >= 0);
    run(1, 1'b1, 1'b1, 1'b0, pc, fp, fl); tot += pc; lv += (fl >= 0);
    run(2, 1'b1, 1'b0, 1'b0, pc, fp, fl); tot += pc; lv += (fl >= 0);
    run(5, 1'b1, 1'b1, 1'b0, pc, fp, fl); tot += pc; lv += (fl >= 0);
    expect_int("bounce_pulses", tot, 0);
    expect_int("bounce_level_segments", lv, 0);

    phase = "repeat";
    run(30, 1'b1, 1'b0, 1'b1, pc, fp, fl);
    expect_int("repeat_held_pulses", pc, 6);
    expect_int("repeat_first_pulse", fp, 6);
    run(10, 1'b1, 1'b1, 1'b1, pc, fp, fl);
    expect_int("repeat_release_pulses", pc, 2);

    phase = "auto_drop";
    run(16, 1'b1, 1'b0, 1'b1, pc, fp, fl);
    expect_int("drop_pre_pulses", pc, 2);
    run(20, 1'b1, 1'b0, 1'b0, pc, fp, fl);
    expect_int("drop_held_pulses", pc, 0);
    run(10, 1'b1, 1'b1, 1'b0, pc, fp, fl);
    expect_int("drop_release_pulses", pc, 0);
    run(12, 1'b1, 1'b0, 1'b0, pc, fp, fl);
    expect_int("drop_repress_pulses", pc, 1);
    expect_int("drop_repress_latency", fp, 6);
    run(10, 1'b1, 1'b1, 1'b0, pc, fp, fl);

    phase = "mid_reset";
    run(20, 1'b1, 1'b0, 1'b1, pc, fp, fl);
    expect_int("midrst_pre_pulses", pc, 3);
    step(1'b0, 1'b0, 1'b1);
    expect_int("midrst_pulse", int'(pulse), 0);
    expect_int("midrst_level", int'(key_level), 0);
    run(10, 1'b1, 1'b0, 1'b1, pc, fp, fl);
    expect_int("midrst_after_latency", fp, 6);
    run(10, 1'b1, 1'b1, 1'b1, pc, fp, fl);

    phase = "random";
    a = 1'b0;
    for (int s = 0; s < 60; s++) begin
      if ($urandom_range(0, 7) == 0) a = ~a;
      k   = logic'($urandom_range(0, 1));
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : int'($urandom_range(5, 25));
      if ($urandom_range(0, 19) == 0) step(1'b0, k, a);
      run(len, 1'b1, k, a, pc, fp, fl);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
